// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0 prefixes,
// tracks Shift/Ctrl/CapsLock and presents one translated key event at a time.
module ps2_scancode_decoder #(
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_nextdata_n,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_caps
);

    typedef enum logic [1:0] {S_IDLE, S_POP, S_DECODE} state_e;

    state_e     state_q, state_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_f_q, ext_f_d, brk_f_q, brk_f_d;
    logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic       ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
    logic       caps_q, caps_d, caps_down_q, caps_down_d;
    logic       last_vld_q, last_vld_d;
    logic [8:0] last_make_q, last_make_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d, key_ascii_q, key_ascii_d;
    logic       key_ext_q, key_ext_d, key_break_q, key_break_d;
    logic       emit, is_rep;
    logic [7:0] ascii_w;

    function automatic logic [7:0] xlate(input logic [7:0] code, input logic shift,
                                         input logic caps, input logic ctrl);
        logic [7:0] lc, lo, hi, res;
        lc = 8'h00;
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = 8'h00;
        endcase
        case (code)
            8'h16: {lo, hi} = {"1", "!"};    8'h1E: {lo, hi} = {"2", "@"};
            8'h26: {lo, hi} = {"3", "#"};    8'h25: {lo, hi} = {"4", "$"};
            8'h2E: {lo, hi} = {"5", "%"};    8'h36: {lo, hi} = {"6", "^"};
            8'h3D: {lo, hi} = {"7", "&"};    8'h3E: {lo, hi} = {"8", "*"};
            8'h46: {lo, hi} = {"9", "("};    8'h45: {lo, hi} = {"0", ")"};
            8'h4E: {lo, hi} = {"-", "_"};    8'h55: {lo, hi} = {"=", "+"};
            8'h54: {lo, hi} = {"[", "{"};    8'h5B: {lo, hi} = {"]", "}"};
            8'h4C: {lo, hi} = {";", ":"};    8'h52: {lo, hi} = {"'", "\""};
            8'h41: {lo, hi} = {",", "<"};    8'h49: {lo, hi} = {".", ">"};
            8'h4A: {lo, hi} = {"/", "?"};    8'h0E: {lo, hi} = {8'h60, "~"};
            8'h5D: {lo, hi} = {"\\", "|"};
            8'h29: {lo, hi} = {8'h20, 8'h20};
            8'h5A: {lo, hi} = {8'h0D, 8'h0D};
            8'h66: {lo, hi} = {8'h08, 8'h08};
            8'h0D: {lo, hi} = {8'h09, 8'h09};
            8'h76: {lo, hi} = {8'h1B, 8'h1B};
            default: {lo, hi} = 16'h0000;
        endcase
        // Ctrl wins over case for letters; caps never affects symbols.
        if (lc != 8'h00) res = ctrl ? (lc - 8'h60) : ((shift ^ caps) ? (lc - 8'h20) : lc);
        else             res = shift ? hi : lo;
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_f_d      = ext_f_q;
        brk_f_d      = brk_f_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;
        ctrl_l_d     = ctrl_l_q;
        ctrl_r_d     = ctrl_r_q;
        caps_d       = caps_q;
        caps_down_d  = caps_down_q;
        last_vld_d   = last_vld_q;
        last_make_d  = last_make_q;
        key_valid_d  = key_valid_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_ascii_d  = key_ascii_q;
        emit         = 1'b0;
        is_rep       = 1'b0;
        ascii_w      = 8'h00;

        if (key_valid_q && key_ack) key_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (kb_ready && !key_valid_q) begin
                    byte_d  = kb_data;
                    state_d = S_POP;
                end
            end
            S_POP: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_IDLE;
                if (byte_q == 8'hE0) begin
                    ext_f_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_f_d = 1'b1;
                end else begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                    // Translate with the modifiers as they were before this byte.
                    if (!ext_f_q && !brk_f_q)
                        ascii_w = xlate(byte_q, shift_l_q | shift_r_q, caps_q, ctrl_l_q | ctrl_r_q);
                    if (!ext_f_q) begin
                        case (byte_q)
                            8'h12: shift_l_d = !brk_f_q;
                            8'h59: shift_r_d = !brk_f_q;
                            8'h14: ctrl_l_d  = !brk_f_q;
                            8'h58: begin
                                if (brk_f_q) begin
                                    caps_down_d = 1'b0;
                                end else begin
                                    if (!caps_down_q) caps_d = !caps_q;
                                    caps_down_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (byte_q == 8'h14) begin
                        ctrl_r_d = !brk_f_q;
                    end
                    is_rep = !brk_f_q && last_vld_q && (last_make_q == {ext_f_q, byte_q});
                    if (!brk_f_q) begin
                        last_vld_d  = 1'b1;
                        last_make_d = {ext_f_q, byte_q};
                    end else if (last_vld_q && (last_make_q == {ext_f_q, byte_q})) begin
                        last_vld_d  = 1'b0;
                    end
                    emit = REPEAT_EN || !is_rep;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Event register is always empty in DECODE, since IDLE only pops when it is.
        if (emit) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_f_q;
            key_break_d = brk_f_q;
            key_ascii_d = ascii_w;
        end
    end

    assign nextdata_n_d = (state_d != S_POP);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_IDLE;
            nextdata_n_q <= 1'b1;
            byte_q       <= 8'h00;
            ext_f_q      <= 1'b0;
            brk_f_q      <= 1'b0;
            shift_l_q    <= 1'b0;
            shift_r_q    <= 1'b0;
            ctrl_l_q     <= 1'b0;
            ctrl_r_q     <= 1'b0;
            caps_q       <= 1'b0;
            caps_down_q  <= 1'b0;
            last_vld_q   <= 1'b0;
            last_make_q  <= 9'h000;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_ascii_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            byte_q       <= byte_d;
            ext_f_q      <= ext_f_d;
            brk_f_q      <= brk_f_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            ctrl_l_q     <= ctrl_l_d;
            ctrl_r_q     <= ctrl_r_d;
            caps_q       <= caps_d;
            caps_down_q  <= caps_down_d;
            last_vld_q   <= last_vld_d;
            last_make_q  <= last_make_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_ascii_q  <= key_ascii_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_break     = key_break_q;
    assign key_ascii     = key_ascii_q;
    assign mod_shift     = shift_l_q | shift_r_q;
    assign mod_ctrl      = ctrl_l_q | ctrl_r_q;
    assign mod_caps      = caps_q;

endmodule
